// File: rtl/output_port_allocator_if.sv
// Request, credit and grant bundle between the input ports and one output port allocator.
// The allocator connects through the slave modport; the requesting side uses master.
interface output_port_allocator_if #(
  parameter int PORTS  = 5,
  parameter int VC_NUM = 4,
  parameter int VC_W   = 2,
  parameter int CNT_W  = 3
);
  logic [PORTS-1:0]        req;
  logic [PORTS*VC_W-1:0]   req_vc;
  logic [PORTS-1:0]        req_head;
  logic [PORTS-1:0]        req_tail;
  logic [VC_NUM-1:0]       credit_in;
  logic [PORTS-1:0]        grant;
  logic [VC_W-1:0]         grant_vc;
  logic                    grant_valid;
  logic [VC_NUM*CNT_W-1:0] credit_cnt;
  logic [VC_NUM-1:0]       vc_busy;
  logic                    credit_err;

  modport master (
    output req, req_vc, req_head, req_tail, credit_in,
    input  grant, grant_vc, grant_valid, credit_cnt, vc_busy, credit_err
  );

  modport slave (
    input  req, req_vc, req_head, req_tail, credit_in,
    output grant, grant_vc, grant_valid, credit_cnt, vc_busy, credit_err
  );
endinterface

// File: rtl/output_port_allocator.sv
// Per-output-port switch/VC allocator: round-robin grant among eligible input ports,
// per-VC packet locking (head..tail) and downstream credit tracking.
module output_port_allocator #(
  parameter int PORTS     = 5,
  parameter int VC_NUM    = 4,
  parameter int VC_W      = 2,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  output_port_allocator_if.slave bus
);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [0:0] VC_FREE  = 1'b0;
  localparam logic [0:0] VC_ALLOC = 1'b1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  logic [PORTS-1:0][VC_W-1:0]   port_vc;
  logic [PORTS-1:0]             elig;
  logic [VC_NUM-1:0][CNT_W-1:0] cnt_vec;
  logic [VC_NUM-1:0]            alloc_vec;
  logic [VC_NUM-1:0][PW-1:0]    owner_vec;
  logic [VC_NUM-1:0]            overflow;

  logic [PW-1:0]    rr_ptr_reg;
  logic [PW-1:0]    rr_ptr_next;
  logic             credit_err_reg;
  logic             credit_err_next;

  logic             arb_hit;
  logic             grant_found;
  logic [PW-1:0]    grant_sel;
  logic [PW:0]      arb_sum;
  logic [PW-1:0]    arb_idx;
  logic [PORTS-1:0] grant_oh;
  logic [VC_W-1:0]  gnt_vc;
  logic             gnt_head;
  logic             gnt_tail;

  genvar gi;

  // A head may only open a FREE VC; body/tail flits only continue the owner's packet.
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port
      logic [VC_W-1:0] vc;
      assign vc          = bus.req_vc[gi*VC_W +: VC_W];
      assign port_vc[gi] = vc;
      assign elig[gi]    = bus.req[gi] && (cnt_vec[vc] != '0) &&
                           (bus.req_head[gi] ? !alloc_vec[vc]
                                             : (alloc_vec[vc] && (owner_vec[vc] == PW'(gi))));
    end
  endgenerate

  always_comb begin
    arb_hit   = 1'b0;
    grant_sel = '0;
    arb_sum   = '0;
    arb_idx   = '0;
    for (int k = 0; k < PORTS; k++) begin
      arb_sum = {1'b0, rr_ptr_reg} + (PW+1)'(k);
      if (arb_sum >= (PW+1)'(PORTS)) begin
        arb_sum = arb_sum - (PW+1)'(PORTS);
      end
      arb_idx = arb_sum[PW-1:0];
      if (!arb_hit && elig[arb_idx]) begin
        arb_hit   = 1'b1;
        grant_sel = arb_idx;
      end
    end
  end

  // Grants are suppressed for as long as reset is held low.
  assign grant_found = arb_hit && reset;

  always_comb begin
    grant_oh = '0;
    gnt_vc   = '0;
    gnt_head = 1'b0;
    gnt_tail = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant_found && (grant_sel == PW'(p))) begin
        grant_oh[p] = 1'b1;
        gnt_vc      = port_vc[p];
        gnt_head    = bus.req_head[p];
        gnt_tail    = bus.req_tail[p];
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_found) begin
      rr_ptr_next = (grant_sel == PW'(PORTS-1)) ? '0 : grant_sel + PW'(1);
    end
  end

  assign credit_err_next = credit_err_reg | (|overflow);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_reg     <= '0;
      credit_err_reg <= 1'b0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      credit_err_reg <= credit_err_next;
    end
  end

  generate
    for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
      logic [0:0]       state_reg;
      logic [0:0]       state_next;
      logic [PW-1:0]    owner_reg;
      logic [PW-1:0]    owner_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             vc_grant;
      logic             vc_credit;

      assign vc_grant     = grant_found && (gnt_vc == VC_W'(gi));
      assign vc_credit    = bus.credit_in[gi];
      assign overflow[gi] = vc_credit && !vc_grant && (cnt_reg == CNT_FULL);

      // A head+tail flit passes through a FREE VC without locking it.
      always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        case (state_reg)
          VC_FREE: begin
            if (vc_grant && gnt_head && !gnt_tail) begin
              state_next = VC_ALLOC;
              owner_next = grant_sel;
            end
          end
          VC_ALLOC: begin
            if (vc_grant && gnt_tail && (grant_sel == owner_reg)) begin
              state_next = VC_FREE;
            end
          end
        endcase
      end

      always_comb begin
        cnt_next = cnt_reg;
        if (vc_grant && !vc_credit) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (vc_credit && !vc_grant && (cnt_reg != CNT_FULL)) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          state_reg <= VC_FREE;
          owner_reg <= '0;
          cnt_reg   <= CNT_FULL;
        end else begin
          state_reg <= state_next;
          owner_reg <= owner_next;
          cnt_reg   <= cnt_next;
        end
      end

      assign cnt_vec[gi]   = cnt_reg;
      assign alloc_vec[gi] = (state_reg == VC_ALLOC);
      assign owner_vec[gi] = owner_reg;
    end
  endgenerate

  assign bus.grant       = grant_oh;
  assign bus.grant_vc    = gnt_vc;
  assign bus.grant_valid = grant_found;
  assign bus.credit_cnt  = cnt_vec;
  assign bus.vc_busy     = alloc_vec;
  assign bus.credit_err  = credit_err_reg;

endmodule

// File: tb/tb_output_port_allocator.sv
// Scoreboard bench for output_port_allocator: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_output_port_allocator;
  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  output_port_allocator_if #(.PORTS(5), .VC_NUM(4), .VC_W(2), .CNT_W(3)) bus ();

  output_port_allocator #(
    .PORTS(5), .VC_NUM(4), .VC_W(2), .BUF_DEPTH(4), .CNT_W(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         id;
    logic [4:0] g;
    logic [1:0] gv;
    bit         chk;
    logic [11:0] cnt;
    logic [3:0] busy;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int step_id = 0;

  bit          st_chk = 1'b0;
  logic [11:0] st_cnt = '0;
  logic [3:0]  st_busy = '0;
  logic        st_err = 1'b0;

  task automatic expect_st(input logic [11:0] cnt, input logic [3:0] busy, input logic err);
    st_chk  = 1'b1;
    st_cnt  = cnt;
    st_busy = busy;
    st_err  = err;
  endtask

  // Drive one cycle of requests/credits and queue what the DUT must show in that cycle.
  task automatic step(input logic [4:0] r, input logic [9:0] vc, input logic [4:0] hd,
                      input logic [4:0] tl, input logic [3:0] cr,
                      input logic [4:0] eg, input logic [1:0] egv);
    exp_t e;
    bus.req       = r;
    bus.req_vc    = vc;
    bus.req_head  = hd;
    bus.req_tail  = tl;
    bus.credit_in = cr;
    e.id   = step_id;
    e.g    = eg;
    e.gv   = egv;
    e.chk  = st_chk;
    e.cnt  = st_cnt;
    e.busy = st_busy;
    e.err  = st_err;
    sb.push_back(e);
    st_chk  = 1'b0;
    step_id = step_id + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] cr);
    step(5'h00, 10'h000, 5'h00, 5'h00, cr, 5'h00, 2'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(5'h1F, 10'h000, 5'h1F, 5'h00, 4'h0, 5'h00, 2'd0);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      $display("step %0d: grant=%b vc=%0d valid=%b cnt=%h busy=%b err=%b",
               mon_e.id, bus.grant, bus.grant_vc, bus.grant_valid,
               bus.credit_cnt, bus.vc_busy, bus.credit_err);
      n_cmp++;
      if (bus.grant !== mon_e.g) begin
        n_bad++;
        $display("FAIL grant step %0d: got %b want %b", mon_e.id, bus.grant, mon_e.g);
      end
      n_cmp++;
      if (bus.grant_vc !== mon_e.gv) begin
        n_bad++;
        $display("FAIL grant_vc step %0d: got %0d want %0d", mon_e.id, bus.grant_vc, mon_e.gv);
      end
      n_cmp++;
      if (bus.grant_valid !== (|mon_e.g)) begin
        n_bad++;
        $display("FAIL grant_valid step %0d: got %b want %b", mon_e.id, bus.grant_valid, |mon_e.g);
      end
      if (mon_e.chk) begin
        n_cmp++;
        if (bus.credit_cnt !== mon_e.cnt) begin
          n_bad++;
          $display("FAIL credit_cnt step %0d: got %h want %h", mon_e.id, bus.credit_cnt, mon_e.cnt);
        end
        n_cmp++;
        if (bus.vc_busy !== mon_e.busy) begin
          n_bad++;
          $display("FAIL vc_busy step %0d: got %b want %b", mon_e.id, bus.vc_busy, mon_e.busy);
        end
        n_cmp++;
        if (bus.credit_err !== mon_e.err) begin
          n_bad++;
          $display("FAIL credit_err step %0d: got %b want %b", mon_e.id, bus.credit_err, mon_e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req       = '0;
    bus.req_vc    = '0;
    bus.req_head  = '0;
    bus.req_tail  = '0;
    bus.credit_in = '0;
    @(posedge clk);
    #1;

    // Reset held with requests present: no grant may appear.
    reset = 1'b0;
    step(5'h1F, 10'h000, 5'h1F, 5'h00, 4'h0, 5'h00, 2'd0);
    step(5'h1F, 10'h000, 5'h1F, 5'h00, 4'h0, 5'h00, 2'd0);
    reset = 1'b1;
    expect_st(12'h924, 4'h0, 1'b0);
    idle(4'h0);

    // Port 2: head/body/tail on VC1, then return the three credits.
    expect_st(12'h924, 4'h0, 1'b0);
    step(5'b00100, 10'h010, 5'b00100, 5'b00000, 4'h0, 5'b00100, 2'd1);
    expect_st(12'h91C, 4'b0010, 1'b0);
    step(5'b00100, 10'h010, 5'b00000, 5'b00000, 4'h0, 5'b00100, 2'd1);
    expect_st(12'h914, 4'b0010, 1'b0);
    step(5'b00100, 10'h010, 5'b00000, 5'b00100, 4'h0, 5'b00100, 2'd1);
    expect_st(12'h90C, 4'h0, 1'b0);
    idle(4'b0010);
    idle(4'b0010);
    idle(4'b0010);
    expect_st(12'h924, 4'h0, 1'b0);
    idle(4'h0);

    // Round robin from rr_ptr=0 among ports 0,1,3 with single-flit packets; credit returned same cycle.
    do_reset();
    expect_st(12'h924, 4'h0, 1'b0);
    step(5'b01011, 10'h084, 5'b01011, 5'b01011, 4'b0001, 5'b00001, 2'd0);
    step(5'b01011, 10'h084, 5'b01011, 5'b01011, 4'b0010, 5'b00010, 2'd1);
    step(5'b01011, 10'h084, 5'b01011, 5'b01011, 4'b0100, 5'b01000, 2'd2);
    step(5'b01011, 10'h084, 5'b01011, 5'b01011, 4'b0001, 5'b00001, 2'd0);
    step(5'b01011, 10'h084, 5'b01011, 5'b01011, 4'b0010, 5'b00010, 2'd1);
    step(5'b01011, 10'h084, 5'b01011, 5'b01011, 4'b0100, 5'b01000, 2'd2);
    expect_st(12'h924, 4'h0, 1'b0);
    idle(4'h0);

    // Port 0 owns VC2; port 4 head on VC2 must wait until port 0's tail.
    step(5'b00001, 10'h002, 5'b00001, 5'b00000, 4'h0, 5'b00001, 2'd2);
    expect_st(12'h8E4, 4'b0100, 1'b0);
    step(5'b10001, 10'h202, 5'b10000, 5'b00000, 4'b0100, 5'b00001, 2'd2);
    step(5'b10001, 10'h202, 5'b10000, 5'b00000, 4'b0100, 5'b00001, 2'd2);
    step(5'b10001, 10'h202, 5'b10000, 5'b00001, 4'h0, 5'b00001, 2'd2);
    expect_st(12'h8A4, 4'h0, 1'b0);
    step(5'b10000, 10'h200, 5'b10000, 5'b10000, 4'h0, 5'b10000, 2'd2);
    expect_st(12'h864, 4'h0, 1'b0);
    idle(4'b0100);
    idle(4'b0100);
    idle(4'b0100);
    expect_st(12'h924, 4'h0, 1'b0);
    idle(4'h0);

    // Port 1 sends five flits on VC3: the fifth waits for a credit, granted the cycle after it.
    step(5'b00010, 10'h00C, 5'b00010, 5'b00000, 4'h0, 5'b00010, 2'd3);
    step(5'b00010, 10'h00C, 5'b00000, 5'b00000, 4'h0, 5'b00010, 2'd3);
    step(5'b00010, 10'h00C, 5'b00000, 5'b00000, 4'h0, 5'b00010, 2'd3);
    step(5'b00010, 10'h00C, 5'b00000, 5'b00000, 4'h0, 5'b00010, 2'd3);
    expect_st(12'h124, 4'b1000, 1'b0);
    step(5'b00010, 10'h00C, 5'b00000, 5'b00010, 4'h0, 5'b00000, 2'd0);
    step(5'b00010, 10'h00C, 5'b00000, 5'b00010, 4'b1000, 5'b00000, 2'd0);
    expect_st(12'h324, 4'b1000, 1'b0);
    step(5'b00010, 10'h00C, 5'b00000, 5'b00010, 4'b1000, 5'b00010, 2'd3);
    expect_st(12'h324, 4'h0, 1'b0);
    idle(4'b1000);
    idle(4'b1000);
    idle(4'b1000);
    expect_st(12'h924, 4'h0, 1'b0);
    idle(4'h0);

    // Credit on a full VC0 sets the sticky error; only reset clears it.
    expect_st(12'h924, 4'h0, 1'b0);
    idle(4'b0001);
    expect_st(12'h924, 4'h0, 1'b1);
    idle(4'h0);
    expect_st(12'h924, 4'h0, 1'b1);
    idle(4'h0);
    do_reset();
    expect_st(12'h924, 4'h0, 1'b0);
    idle(4'h0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
